multicycle_ctrl: RTL

- Moore-style control FSM that sequences a multicycle version of the 8-bit RISC-V datapath: PC, register file, ULA, and a shared instruction/data memory.
- Replaces the single-cycle combinational control unit.
- Each instruction is split into FETCH / DECODE / EXECUTE / MEM / WRITEBACK steps, and the block issues per-step strobes and mux selects.
- Also provides single-step gating, a sticky halt on unsupported opcodes, and a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle 8-bit RISC-V datapath.
// It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and
// decodes the per-step strobes and mux selects from the current state.
// It also provides advance gating (en), a sticky halt on unsupported
// encodings, and a wrapping count of retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       ula_src_a,
  output logic [1:0]       ula_src_b,
  output logic             imm_src,
  output logic [1:0]       result_src,
  output logic [2:0]       ula_control,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_HALT     = 4'd15
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Raw (ungated) strobes decoded from the state.
  logic pc_write_s, ir_write_s, mem_write_s, reg_write_s;
  logic retire_s;

  // Only these funct3 values have an ALU operation behind them.
  function automatic logic funct3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // sub_ok is set only for R-type, so I-type never selects sub.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                            input logic sub_ok);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = (sub_ok && f7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  ctl = ALU_AND;
      3'b110:  ctl = ALU_OR;
      3'b010:  ctl = ALU_SLT;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance only when enabled; HALT is left only by reset.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          if ((op == OP_R) && funct3_legal(funct3)) begin
            state_d = S_EXEC_R;
          end else if ((op == OP_I) && funct3_legal(funct3)) begin
            state_d = S_EXEC_I;
          end else if ((op == OP_LW) || (op == OP_SW)) begin
            state_d = S_MEMADR;
          end else begin
            state_d = S_HALT;
          end
        end
        S_MEMADR: begin
          if (op == OP_LW) begin
            state_d = S_MEMREAD;
          end else if (op == OP_SW) begin
            state_d = S_MEMWRITE;
          end else begin
            state_d = S_HALT;
          end
        end
        S_MEMREAD:  state_d = S_MEMWB;
        S_MEMWB:    state_d = S_FETCH;
        S_MEMWRITE: state_d = S_FETCH;
        S_EXEC_R:   state_d = S_ALUWB;
        S_EXEC_I:   state_d = S_ALUWB;
        S_ALUWB:    state_d = S_FETCH;
        S_HALT:     state_d = S_HALT;
        default:    state_d = S_HALT;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A retirement is the enabled edge leaving a final step of an instruction.
  always_comb begin
    retire_s = (state_q == S_ALUWB) || (state_q == S_MEMWB) || (state_q == S_MEMWRITE);
    if (en && retire_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Moore output decode; anything not set for a state stays at zero / add.
  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    adr_src     = 1'b0;
    ula_src_a   = 2'b00;
    ula_src_b   = 2'b00;
    imm_src     = 1'b0;
    result_src  = 2'b00;
    ula_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        ula_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        ula_src_a = 2'b01;
        ula_src_b = 2'b01;
      end
      S_MEMADR: begin
        ula_src_a = 2'b10;
        ula_src_b = 2'b01;
        imm_src   = (op == OP_SW);
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXEC_R: begin
        ula_src_a   = 2'b10;
        ula_control = alu_decode(funct3, funct7[5], 1'b1);
      end
      S_EXEC_I: begin
        ula_src_a   = 2'b10;
        ula_src_b   = 2'b01;
        ula_control = alu_decode(funct3, funct7[5], 1'b0);
      end
      S_ALUWB:    reg_write_s = 1'b1;
      S_HALT:     ula_control = ALU_ADD;
      default:    ula_control = ALU_ADD;
    endcase
  end

  // Strobes are gated combinationally so that neither a freeze nor a falling
  // reset can leak a partial write from the current state.
  assign pc_write    = pc_write_s  & en & rst;
  assign ir_write    = ir_write_s  & en & rst;
  assign mem_write   = mem_write_s & en & rst;
  assign reg_write   = reg_write_s & en & rst;
  assign halted      = (state_q == S_HALT);
  assign state       = state_q;
  assign instr_count = count_q;

endmodule
